// File: rtl/bala_car_position_pkg.sv
// Shared types and default sizing for the elevator car position model and its controller.
package bala_car_position_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } car_state_e;

  typedef logic [4:0] floor_t;

  localparam int DEF_NUM_FLOORS    = 5;
  localparam int DEF_TRAVEL_CYCLES = 8;
  localparam int DEF_DOOR_CYCLES   = 4;

endpackage

// File: rtl/bala_dwell_timer.sv
// Load/decrement down-counter; done flags the last clock of the loaded interval.
module bala_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == W'(1));

endmodule

// File: rtl/bala_car_position.sv
// Elevator car position model: steps a position counter while driven, reports floors,
// holds the door for a fixed dwell and flags commands that would run past the shaft ends.
module bala_car_position
  import bala_car_position_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   motor,
  input  logic   direction,
  output floor_t floor_cur,
  output logic   at_floor,
  output logic   arrive,
  output logic   door_open,
  output logic   limit_hit
);

  localparam int          MAX_POS  = (NUM_FLOORS - 1) * TRAVEL_CYCLES;
  localparam int          POS_W    = $clog2(MAX_POS) + 1;
  localparam logic [31:0] TRAVEL_U = 32'(TRAVEL_CYCLES);
  localparam floor_t      TOP      = floor_t'(NUM_FLOORS - 1);

  car_state_e       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  floor_t           floor_q, floor_d;
  logic             at_floor_q, at_floor_d;
  logic             arrive_q, arrive_d;
  logic             door_open_q, door_open_d;
  logic             limit_hit_q, limit_hit_d;
  logic             limit_cmd_q, limit_cmd_d;
  logic             dir_q;

  logic             blocked;
  logic             step_en;
  logic             door_load;
  logic             door_done;
  logic [31:0]      pos_ext;

  // The car may only be blocked while level with an end floor.
  assign blocked = at_floor_q &&
                   ((direction && (floor_q == TOP)) || (!direction && (floor_q == '0)));
  assign step_en   = motor && !blocked && (state_q != DOOR);
  assign door_load = (state_q == MOVE) && !motor && at_floor_q;

  bala_dwell_timer #(
    .W (8)
  ) u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (door_load),
    .load_val (8'(DOOR_CYCLES)),
    .dec      (state_q == DOOR),
    .done     (door_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      floor_q     <= '0;
      at_floor_q  <= 1'b1;
      arrive_q    <= 1'b0;
      door_open_q <= 1'b0;
      limit_hit_q <= 1'b0;
      limit_cmd_q <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      floor_q     <= floor_d;
      at_floor_q  <= at_floor_d;
      arrive_q    <= arrive_d;
      door_open_q <= door_open_d;
      limit_hit_q <= limit_hit_d;
      limit_cmd_q <= limit_cmd_d;
      dir_q       <= direction;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (step_en) state_d = MOVE;
      MOVE:    if (!motor) state_d = at_floor_q ? DOOR : IDLE;
      DOOR:    if (door_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pos_d = pos_q;
    if (step_en) begin
      pos_d = direction ? (pos_q + 1'b1) : (pos_q - 1'b1);
    end
    pos_ext     = 32'(pos_d);
    at_floor_d  = ((pos_ext % TRAVEL_U) == 32'd0);
    arrive_d    = step_en && at_floor_d;
    floor_d     = arrive_d ? floor_t'(pos_ext / TRAVEL_U) : floor_q;
    door_open_d = (state_d == DOOR);
    // A held blocked command reports once; re-arms on motor release or a direction change.
    limit_cmd_d = motor && blocked && (state_q != DOOR);
    limit_hit_d = limit_cmd_d && (!limit_cmd_q || (direction != dir_q));
  end

  assign floor_cur = floor_q;
  assign at_floor  = at_floor_q;
  assign arrive    = arrive_q;
  assign door_open = door_open_q;
  assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_bala_car_position.sv
// Table-driven check of the car position model with default sizing (5 floors, 8 clk/floor, 4 clk door).
module tb_bala_car_position;
  import bala_car_position_pkg::*;

  logic   clk;
  logic   rst;
  logic   motor;
  logic   direction;
  floor_t floor_cur;
  logic   at_floor;
  logic   arrive;
  logic   door_open;
  logic   limit_hit;

  int checks   = 0;
  int failures = 0;

  bala_car_position dut (
    .clk       (clk),
    .rst       (rst),
    .motor     (motor),
    .direction (direction),
    .floor_cur (floor_cur),
    .at_floor  (at_floor),
    .arrive    (arrive),
    .door_open (door_open),
    .limit_hit (limit_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       motor;
    logic       dir;
    int         n;
    int         floor;
    logic       at;
    logic       arr;
    logic       door;
    logic       lim;
    int         pos;
    car_state_e st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic m, logic d, int n, int fl, logic at, logic arr,
                              logic door, logic lim, int pos, car_state_e st);
    vec_t v;
    v.rst_n = r; v.motor = m; v.dir = d; v.n = n; v.floor = fl; v.at = at; v.arr = arr;
    v.door = door; v.lim = lim; v.pos = pos; v.st = st;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int door_cnt;
    bit seen;
    rst = 1'b0; motor = 1'b0; direction = 1'b0;

    //            rst m  d  n  fl at arr dr lim pos st
    vecs.push_back(mk(0, 0, 0, 2, 0, 1, 0, 0, 0,  0, IDLE)); // reset
    vecs.push_back(mk(1, 1, 1, 8, 1, 1, 1, 0, 0,  8, MOVE)); // first floor after 8 clocks
    vecs.push_back(mk(1, 1, 1, 8, 2, 1, 1, 0, 0, 16, MOVE));
    vecs.push_back(mk(1, 1, 0, 3, 2, 0, 0, 0, 0, 13, MOVE)); // down 3
    vecs.push_back(mk(1, 0, 0, 2, 2, 0, 0, 0, 0, 13, IDLE)); // stop between floors
    vecs.push_back(mk(1, 1, 1, 3, 2, 1, 1, 0, 0, 16, MOVE)); // reverse back to floor 2
    vecs.push_back(mk(1, 1, 1, 8, 3, 1, 1, 0, 0, 24, MOVE));
    vecs.push_back(mk(1, 0, 1, 1, 3, 1, 0, 1, 0, 24, DOOR)); // motor dropped on arrive
    vecs.push_back(mk(1, 1, 1, 3, 3, 1, 0, 1, 0, 24, DOOR)); // motor ignored in door
    vecs.push_back(mk(1, 0, 1, 1, 3, 1, 0, 0, 0, 24, IDLE)); // door closed after 4
    vecs.push_back(mk(1, 1, 1, 8, 4, 1, 1, 0, 0, 32, MOVE));
    vecs.push_back(mk(1, 1, 1, 1, 4, 1, 0, 0, 1, 32, MOVE)); // top limit
    vecs.push_back(mk(1, 1, 1, 9, 4, 1, 0, 0, 0, 32, MOVE)); // held: no repeat
    vecs.push_back(mk(1, 0, 1, 1, 4, 1, 0, 1, 0, 32, DOOR));
    vecs.push_back(mk(1, 0, 1, 3, 4, 1, 0, 1, 0, 32, DOOR));
    vecs.push_back(mk(1, 0, 1, 1, 4, 1, 0, 0, 0, 32, IDLE));
    vecs.push_back(mk(1, 1, 1, 1, 4, 1, 0, 0, 1, 32, IDLE)); // new motor edge re-pulses
    vecs.push_back(mk(1, 1, 0, 1, 4, 0, 0, 0, 0, 31, MOVE)); // downward is free
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0,  0, IDLE)); // reset mid-move
    vecs.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0,  5, MOVE));
    vecs.push_back(mk(1, 1, 0, 5, 0, 1, 1, 0, 0,  0, MOVE)); // reversal: only floor 0 arrive
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 1,  0, MOVE)); // bottom limit
    vecs.push_back(mk(1, 1, 1, 8, 1, 1, 1, 0, 0,  8, MOVE));
    vecs.push_back(mk(1, 1, 1, 8, 2, 1, 1, 0, 0, 16, MOVE));
    vecs.push_back(mk(1, 1, 1, 8, 3, 1, 1, 0, 0, 24, MOVE));
    vecs.push_back(mk(1, 0, 1, 1, 3, 1, 0, 1, 0, 24, DOOR));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0,  0, IDLE)); // reset mid-door

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        rst = vecs[i].rst_n; motor = vecs[i].motor; direction = vecs[i].dir;
        @(posedge clk);
        #1;
        if (k < vecs[i].n - 1) begin
          chk($sformatf("r%0d_arrive_mid%0d", i, k), int'(arrive), 0);
          chk($sformatf("r%0d_limit_mid%0d", i, k), int'(limit_hit), 0);
        end else begin
          chk($sformatf("r%0d_floor", i), int'(floor_cur), vecs[i].floor);
          chk($sformatf("r%0d_at_floor", i), int'(at_floor), int'(vecs[i].at));
          chk($sformatf("r%0d_arrive", i), int'(arrive), int'(vecs[i].arr));
          chk($sformatf("r%0d_door", i), int'(door_open), int'(vecs[i].door));
          chk($sformatf("r%0d_limit", i), int'(limit_hit), int'(vecs[i].lim));
          chk($sformatf("r%0d_pos", i), int'(dut.pos_q), vecs[i].pos);
          chk($sformatf("r%0d_state", i), int'(dut.state_q), int'(vecs[i].st));
        end
      end
      $display("row %0d: rst=%0d motor=%0d dir=%0d n=%0d -> floor=%0d at=%0d arr=%0d door=%0d lim=%0d",
               i, vecs[i].rst_n, vecs[i].motor, vecs[i].dir, vecs[i].n, floor_cur, at_floor,
               arrive, door_open, limit_hit);
    end

    // Door dwell length measured directly, bounded against a stuck door.
    rst = 1'b1; motor = 1'b1; direction = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("dwell_arrive", int'(arrive), 1);
    motor = 1'b0;
    door_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (door_open) begin
        door_cnt++;
        seen = 1'b1;
        motor = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    chk("dwell_cycles", door_cnt, 4);
    chk("dwell_floor", int'(floor_cur), 1);
    chk("dwell_pos", int'(dut.pos_q), 8);
    $display("dwell: door_open cycles=%0d floor=%0d", door_cnt, floor_cur);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
